// File: rtl/mux_pipe_multi.sv
// Merges one unbuffered "in" stream with NFWD FIFO-buffered forward streams onto a single
// ENA/RDY output, using fixed-priority or round-robin arbitration.
module mux_pipe_multi #(
  parameter  int WIDTH = 128,
  parameter  int NFWD  = 2,
  parameter  int DEPTH = 4,
  parameter  int RR    = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_enq__ENA,
  input  logic [WIDTH-1:0]       in_enq_v,
  output logic                   in_enq__RDY,
  input  logic [NFWD-1:0]        forward_enq__ENA,
  input  logic [NFWD*WIDTH-1:0]  forward_enq_v,
  output logic [NFWD-1:0]        forward_enq__RDY,
  output logic [NFWD*CW-1:0]     forward_count,
  output logic                   out_enq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  input  logic                   out_enq__RDY
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NS = NFWD + 1;
  localparam int SW = $clog2(NS);

  logic [WIDTH-1:0] mem [NFWD][DEPTH];
  logic [PW-1:0]    wr_ptr [NFWD];
  logic [PW-1:0]    rd_ptr [NFWD];
  logic [CW-1:0]    count  [NFWD];
  logic [SW-1:0]    rr_ptr;

  logic [WIDTH-1:0] head [NFWD];
  logic [NFWD-1:0]  nonempty;
  logic [NFWD-1:0]  not_full;
  logic [NFWD-1:0]  enq;
  logic [NFWD-1:0]  deq;
  logic [NS-1:0]    eligible;
  logic [SW-1:0]    start;
  logic [2*NS-1:0]  elig_dbl;
  logic [2*NS-1:0]  ne_dbl;
  logic [NS-1:0]    elig_rot;
  logic [NS-1:0]    ne_rot;
  logic [SW-1:0]    first_k;
  logic [SW:0]      gsum;
  logic [SW-1:0]    pos_in;
  logic [SW-1:0]    grant;
  logic [SW-1:0]    rr_next;
  logic             any_eligible;
  logic             in_blocked;
  logic             xfer;
  logic [WIDTH-1:0] payload;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NFWD; i++) begin
      nonempty[i] = (count[i] != '0);
      not_full[i] = (count[i] < CW'(DEPTH));
      head[i]     = mem[i][rd_ptr[i]];
      enq[i]      = forward_enq__ENA[i] & not_full[i];
    end
  end

  // Both sources and FIFO occupancy are rotated so that position 0 is the
  // highest-priority source in the current order; arbitration then scans upward.
  always_comb begin
    eligible     = {in_enq__ENA, nonempty};
    start        = (RR != 0) ? rr_ptr : '0;
    elig_dbl     = {eligible, eligible} >> start;
    ne_dbl       = {1'b0, nonempty, 1'b0, nonempty} >> start;
    elig_rot     = elig_dbl[NS-1:0];
    ne_rot       = ne_dbl[NS-1:0];
    any_eligible = |eligible;
    first_k      = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (elig_rot[k]) first_k = SW'(k);
    end
    gsum  = {1'b0, start} + {1'b0, first_k};
    grant = (gsum >= (SW + 1)'(NS)) ? SW'(gsum - (SW + 1)'(NS)) : gsum[SW-1:0];
    pos_in     = SW'(NFWD) - start;
    in_blocked = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if ((SW'(k) < pos_in) && ne_rot[k]) in_blocked = 1'b1;
    end
    rr_next = (grant == SW'(NFWD)) ? '0 : grant + SW'(1);
  end

  always_comb begin
    payload = in_enq_v;
    for (int i = 0; i < NFWD; i++) begin
      if (grant == SW'(i)) payload = head[i];
    end
  end

  always_comb begin
    xfer = any_eligible & out_enq__RDY & ~RST;
    for (int i = 0; i < NFWD; i++) begin
      deq[i] = xfer & (grant == SW'(i));
    end
  end

  // Everything visible is forced to zero while reset is held, not just after the edge.
  always_comb begin
    in_enq__RDY  = ~RST & out_enq__RDY & ~in_blocked;
    out_enq__ENA = ~RST & any_eligible;
    out_enq_v    = (RST || !any_eligible) ? '0 : payload;
    for (int i = 0; i < NFWD; i++) begin
      forward_enq__RDY[i]         = ~RST & not_full[i];
      forward_count[i*CW +: CW]   = RST ? '0 : count[i];
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NFWD; i++) begin
      if (enq[i]) mem[i][wr_ptr[i]] <= forward_enq_v[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NFWD; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (enq[i]) wr_ptr[i] <= bump(wr_ptr[i]);
        if (deq[i]) rd_ptr[i] <= bump(rd_ptr[i]);
        case ({enq[i], deq[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
      if (xfer) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_mux_pipe_multi.sv
// Bench for mux_pipe_multi: a fixed-priority and a round-robin instance driven side by side,
// checked every cycle against queue-based reference models plus directed spot checks.
module tb_mux_pipe_multi;

  localparam int WIDTH = 128;
  localparam int NFWD  = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NS    = NFWD + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  out_rdy;
  logic                  in_want;
  logic [NFWD-1:0]       fwd_want;
  logic [WIDTH-1:0]      in_v;
  logic [NFWD*WIDTH-1:0] fwd_v;

  logic                  in_ena   [2];
  logic                  in_rdy   [2];
  logic [NFWD-1:0]       fwd_ena  [2];
  logic [NFWD-1:0]       fwd_rdy  [2];
  logic [NFWD*CW-1:0]    cnt      [2];
  logic                  out_ena  [2];
  logic [WIDTH-1:0]      out_v    [2];

  // Producers only assert ENA while the matching RDY is high.
  assign in_ena[0]  = in_want & in_rdy[0];
  assign in_ena[1]  = in_want & in_rdy[1];
  assign fwd_ena[0] = fwd_want & fwd_rdy[0];
  assign fwd_ena[1] = fwd_want & fwd_rdy[1];

  mux_pipe_multi #(.WIDTH(WIDTH), .NFWD(NFWD), .DEPTH(DEPTH), .RR(0)) dut_fixed (
    .CLK              (clk),
    .RST              (rst),
    .in_enq__ENA      (in_ena[0]),
    .in_enq_v         (in_v),
    .in_enq__RDY      (in_rdy[0]),
    .forward_enq__ENA (fwd_ena[0]),
    .forward_enq_v    (fwd_v),
    .forward_enq__RDY (fwd_rdy[0]),
    .forward_count    (cnt[0]),
    .out_enq__ENA     (out_ena[0]),
    .out_enq_v        (out_v[0]),
    .out_enq__RDY     (out_rdy)
  );

  mux_pipe_multi #(.WIDTH(WIDTH), .NFWD(NFWD), .DEPTH(DEPTH), .RR(1)) dut_rr (
    .CLK              (clk),
    .RST              (rst),
    .in_enq__ENA      (in_ena[1]),
    .in_enq_v         (in_v),
    .in_enq__RDY      (in_rdy[1]),
    .forward_enq__ENA (fwd_ena[1]),
    .forward_enq_v    (fwd_v),
    .forward_enq__RDY (fwd_rdy[1]),
    .forward_count    (cnt[1]),
    .out_enq__ENA     (out_ena[1]),
    .out_enq_v        (out_v[1]),
    .out_enq__RDY     (out_rdy)
  );

  logic [WIDTH-1:0] mq [2*NFWD][$];
  int rr [2];
  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randData();
    for (int w = 0; w < WIDTH / 32; w++) in_v[w*32 +: 32] = $urandom;
    for (int w = 0; w < NFWD * WIDTH / 32; w++) fwd_v[w*32 +: 32] = $urandom;
  endtask

  // One clock: at the falling edge compare every output of both instances with the
  // reference models, then advance the models with what the rising edge will do.
  task automatic applyStimulus();
    int start, g, pos;
    bit blocked, seen;
    logic [WIDTH-1:0] ev;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      start   = (d == 1) ? rr[d] : 0;
      g       = -1;
      blocked = 1'b0;
      seen    = 1'b0;
      for (int k = 0; k < NS; k++) begin
        pos = (start + k) % NS;
        if (pos == NFWD) begin
          seen = 1'b1;
          if (g < 0 && in_ena[d]) g = pos;
        end else if (mq[d*NFWD + pos].size() > 0) begin
          if (!seen) blocked = 1'b1;
          if (g < 0) g = pos;
        end
      end
      checkOutput($sformatf("d%0d out_ena", d), out_ena[d], (!rst && g >= 0));
      if (rst || g < 0) ev = '0;
      else if (g == NFWD) ev = in_v;
      else ev = mq[d*NFWD + g][0];
      if (rst || g >= 0) checkOutput($sformatf("d%0d out_v", d), out_v[d], ev);
      checkOutput($sformatf("d%0d in_rdy", d), in_rdy[d], (!rst && out_rdy && !blocked));
      for (int i = 0; i < NFWD; i++) begin
        checkOutput($sformatf("d%0d fwd_rdy%0d", d, i), fwd_rdy[d][i],
                    (!rst && mq[d*NFWD + i].size() < DEPTH));
        checkOutput($sformatf("d%0d count%0d", d, i), cnt[d][i*CW +: CW],
                    rst ? 0 : mq[d*NFWD + i].size());
      end
      if (rst) begin
        for (int i = 0; i < NFWD; i++) mq[d*NFWD + i].delete();
        rr[d] = 0;
      end else begin
        if (g >= 0 && out_rdy) begin
          if (g < NFWD) void'(mq[d*NFWD + g].pop_front());
          rr[d] = (g + 1) % NS;
        end
        for (int i = 0; i < NFWD; i++) begin
          if (fwd_ena[d][i]) mq[d*NFWD + i].push_back(fwd_v[i*WIDTH +: WIDTH]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rr[0] = 0;
    rr[1] = 0;
    rst      = 1'b1;
    out_rdy  = 1'b1;
    in_want  = 1'b1;
    fwd_want = '1;
    randData();

    // Reset held with every producer requesting.
    repeat (3) applyStimulus();
    rst      = 1'b0;
    in_want  = 1'b0;
    fwd_want = '0;
    applyStimulus();

    // Zero-latency bypass of the in path.
    in_want = 1'b1;
    in_v    = {16{8'hA5}};
    out_rdy = 1'b1;
    #2;
    checkOutput("bypass_ena", out_ena[0], 1);
    checkOutput("bypass_v_fixed", out_v[0], {16{8'hA5}});
    checkOutput("bypass_v_rr", out_v[1], {16{8'hA5}});
    applyStimulus();
    in_want = 1'b0;

    // Fill forward channel 0 past its depth with the output stalled, then drain.
    out_rdy  = 1'b0;
    fwd_want = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      fwd_v = '0;
      fwd_v[0 +: WIDTH] = WIDTH'(k);
      applyStimulus();
    end
    checkOutput("full_count", cnt[0][CW-1:0], 4);
    checkOutput("full_rdy", fwd_rdy[0][0], 0);
    fwd_want = '0;
    out_rdy  = 1'b1;
    #2;
    checkOutput("drain_first", out_v[0], 1);
    applyStimulus();
    checkOutput("rdy_after_pop", fwd_rdy[0][0], 1);
    repeat (4) applyStimulus();

    // Two words in each FIFO, then the in path competes for the output.
    out_rdy  = 1'b0;
    fwd_want = 2'b11;
    repeat (2) begin
      randData();
      applyStimulus();
    end
    fwd_want = '0;
    in_want  = 1'b1;
    out_rdy  = 1'b1;
    #2;
    checkOutput("in_held_off", in_rdy[0], 0);
    repeat (5) begin
      randData();
      applyStimulus();
    end
    in_want = 1'b0;
    applyStimulus();

    // All sources continuously requesting.
    fwd_want = 2'b11;
    in_want  = 1'b1;
    repeat (12) begin
      randData();
      applyStimulus();
    end
    fwd_want = '0;
    in_want  = 1'b0;
    repeat (6) applyStimulus();

    // Reset arriving just after the first pop of a queued channel.
    out_rdy  = 1'b0;
    fwd_want = 2'b10;
    repeat (3) begin
      randData();
      applyStimulus();
    end
    fwd_want = '0;
    out_rdy  = 1'b1;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("post_reset_count", cnt[0][2*CW-1:CW], 0);
    checkOutput("post_reset_ena", out_ena[0], 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      in_want  = $urandom_range(0, 1);
      fwd_want = NFWD'($urandom_range(0, (1 << NFWD) - 1));
      out_rdy  = ($urandom_range(0, 3) != 0);
      randData();
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
